// File: rtl/debounce_pkg.sv
// Shared types and default parameter values for the multi-channel debouncer.
// The optional auto-repeat pulse is enabled by defining DEBOUNCE_REPEAT_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT0 = 2'b01,
    ONE   = 2'b10,
    WAIT1 = 2'b11
  } state_e;

  localparam int unsigned DefCntW       = 21;
  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefRptW       = 24;

endpackage

// File: rtl/debounce_multi_if.sv
// Raw switch inputs and debounced outputs of debounce_multi, CH bits wide.
interface debounce_multi_if #(
  parameter int unsigned CH = 4
);

  logic [CH-1:0] sw;
  logic [CH-1:0] db_level;
  logic [CH-1:0] db_rise;
  logic [CH-1:0] db_fall;
  logic [CH-1:0] db_repeat;

  modport master (
    output sw,
    input  db_level,
    input  db_rise,
    input  db_fall,
    input  db_repeat
  );

  modport slave (
    input  sw,
    output db_level,
    output db_rise,
    output db_fall,
    output db_repeat
  );

endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, hold-time FSM, registered level/pulses and,
// with DEBOUNCE_REPEAT_EN defined, an auto-repeat counter.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned RPT_W       = DefRptW
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  state_e           state_q;
  logic [CNT_W-1:0] q_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ZERO;
      q_q     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ZERO: begin
          if (s) begin
            state_q <= WAIT1;
            q_q     <= '1;
          end
        end
        WAIT1: begin
          if (!s) begin
            state_q <= ZERO;
          end else if (q_q == CNT_W'(1)) begin
            state_q <= ONE;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            q_q <= q_q - CNT_W'(1);
          end
        end
        ONE: begin
          if (!s) begin
            state_q <= WAIT0;
            q_q     <= '1;
          end
        end
        WAIT0: begin
          if (s) begin
            state_q <= ONE;
          end else if (q_q == CNT_W'(1)) begin
            state_q <= ZERO;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            q_q <= q_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ZERO;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
  logic [RPT_W-1:0] rpt_q;
  logic             repeat_q;

  // Counter only runs while settled high; any other state holds it at zero, so
  // every entry into ONE starts a fresh period.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q    <= '0;
      repeat_q <= 1'b0;
    end else if (state_q == ONE && s) begin
      rpt_q    <= rpt_q + RPT_W'(1);
      repeat_q <= (rpt_q == {RPT_W{1'b1}});
    end else begin
      rpt_q    <= '0;
      repeat_q <= 1'b0;
    end
  end

  assign repeat_o = repeat_q;
`else
  logic [RPT_W-1:0] unused_rpt;
  assign unused_rpt = '0;
  assign repeat_o   = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// CH independent debounce channels; auto-repeat enabled by DEBOUNCE_REPEAT_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned RPT_W       = DefRptW
) (
  input logic             clk,
  input logic             reset,
  debounce_multi_if.slave bus
);

  logic [CH-1:0] sw;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] rpt;

  assign sw = bus.sw;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .RPT_W      (RPT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .sw_i    (sw[i]),
      .level_o (level[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i]),
      .repeat_o(rpt[i])
    );
  end

  assign bus.db_level  = level;
  assign bus.db_rise   = rise;
  assign bus.db_fall   = fall;
  assign bus.db_repeat = rpt;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random bounce, checked each cycle
// against a run-length model of the debounce rules.
module tb_debounce_multi;

  localparam int unsigned CH          = 4;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned RPT_W       = 3;
  localparam int          Win         = 1 << CNT_W;
  localparam int          Rpt         = 1 << RPT_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  debounce_multi_if #(.CH(CH)) bus ();

  debounce_multi #(
    .CH         (CH),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .RPT_W      (RPT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: s is sw delayed SYNC_STAGES samples; the level flips once s has
  // disagreed with it for Win consecutive edges.
  int hist[CH][SYNC_STAGES];
  int lvl[CH];
  int run[CH];
  int held[CH];
  int rise_seen[CH];
  int fall_seen[CH];
  logic [CH-1:0] exp_level, exp_rise, exp_fall, exp_rep;

  task automatic model_edge(input logic [CH-1:0] sw_v, input logic rst);
    int s;
    exp_rise = '0;
    exp_fall = '0;
    exp_rep  = '0;
    for (int i = 0; i < CH; i++) begin
      if (rst) begin
        lvl[i]  = 0;
        run[i]  = 0;
        held[i] = 0;
        for (int j = 0; j < SYNC_STAGES; j++) hist[i][j] = 0;
      end else begin
        s = hist[i][SYNC_STAGES-1];
        for (int j = SYNC_STAGES - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = int'(sw_v[i]);
        if (s != lvl[i]) begin
          run[i]++;
          held[i] = 0;
          if (run[i] == Win) begin
            lvl[i] = s;
            run[i] = 0;
            if (s != 0) exp_rise[i] = 1'b1;
            else exp_fall[i] = 1'b1;
          end
        end else if (run[i] != 0) begin
          run[i]  = 0;
          held[i] = 0;
        end else if (lvl[i] != 0) begin
          held[i]++;
          if (held[i] % Rpt == 0) exp_rep[i] = 1'b1;
        end
      end
      exp_level[i] = (lvl[i] != 0);
    end
`ifndef DEBOUNCE_REPEAT_EN
    exp_rep = '0;
`endif
  endtask

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic [CH-1:0] sw_v, input logic rst);
    bus.sw = sw_v;
    reset  = rst;
    @(posedge clk);
    model_edge(sw_v, rst);
    #1;
    check("level", bus.db_level, exp_level);
    check("rise", bus.db_rise, exp_rise);
    check("fall", bus.db_fall, exp_fall);
    check("repeat", bus.db_repeat, exp_rep);
    for (int i = 0; i < CH; i++) begin
      if (bus.db_rise[i]) rise_seen[i]++;
      if (bus.db_fall[i]) fall_seen[i]++;
    end
  endtask

  task automatic hold(input logic [CH-1:0] sw_v, input int n);
    for (int k = 0; k < n; k++) step(sw_v, 1'b0);
  endtask

  initial begin
    int lat;
    logic [CH-1:0] rsw;
    int p;

    bus.sw = '0;
    reset  = 1'b1;
    for (int i = 0; i < CH; i++) begin
      rise_seen[i] = 0;
      fall_seen[i] = 0;
    end
    for (int k = 0; k < 3; k++) step('0, 1'b1);
    check("reset_level", bus.db_level, 4'b0000);

    // Clean rise on channel 0: level and pulse exactly on edge 18.
    hold(4'b0001, 17);
    check("pre_edge18_level", bus.db_level, 4'b0000);
    step(4'b0001, 1'b0);
    check("edge18_rise", bus.db_rise, 4'b0001);
    check("edge18_level", bus.db_level, 4'b0001);
    step(4'b0001, 1'b0);
    check("edge19_rise", bus.db_rise, 4'b0000);
    hold(4'b0001, 10);

    // Bounce on channel 1: 10 high, 2 low, 20 high gives a single rise.
    rise_seen[1] = 0;
    fall_seen[1] = 0;
    hold(4'b0011, 10);
    hold(4'b0001, 2);
    hold(4'b0011, 20);
    check_int("bounce_rise_cnt", rise_seen[1], 1);
    check_int("bounce_fall_cnt", fall_seen[1], 0);

    // Short low glitch on channel 0 is ignored, then a real release.
    fall_seen[0] = 0;
    hold(4'b0010, 5);
    hold(4'b0011, 25);
    check_int("glitch_fall_cnt", fall_seen[0], 0);
    check("glitch_level", bus.db_level, 4'b0011);
    hold(4'b0010, 25);
    check_int("release_fall_cnt", fall_seen[0], 1);

    // All channels low, then all rise together.
    hold(4'b0000, 25);
    hold(4'b1111, 25);
    check("simul_level", bus.db_level, 4'b1111);

    // Reset in the middle of a rise window on channel 2.
    hold(4'b0000, 25);
    hold(4'b0100, 10);
    step(4'b0100, 1'b1);
    check("midreset_level", bus.db_level, 4'b0000);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      step(4'b0100, 1'b0);
      if (bus.db_rise[2]) lat = k;
    end
    check_int("midreset_latency", lat, 18);

    // Long hold on channel 3 exercises auto-repeat.
    hold(4'b0000, 25);
    hold(4'b1000, 45);
    hold(4'b0000, 25);

    // Random bounce with varying flip rates and occasional reset.
    rsw = '0;
    for (int seg = 0; seg < 12; seg++) begin
      p = (seg % 3 == 0) ? 4 : ((seg % 3 == 1) ? 14 : 60);
      for (int k = 0; k < 50; k++) begin
        for (int i = 0; i < CH; i++) begin
          if ($urandom_range(p - 1, 0) == 0) rsw[i] = ~rsw[i];
        end
        step(rsw, ($urandom_range(199, 0) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
